// File: rtl/cordic_y_last_stage_drain.sv
// Output end of the CORDIC Y path: quadrant/valid delay line, round+saturate, 2-entry output buffer owning pipeline CE.
// Define CORDIC_Y_ROUND_EN for round-half-up; otherwise the Y word is truncated.
module cordic_y_last_stage_drain #(
    parameter int W      = 16,
    parameter int GUARD  = 2,
    parameter int STAGES = 16
) (
    input  logic                 C,
    input  logic                 RN,
    input  logic                 in_valid,
    input  logic                 Z_30,
    input  logic                 Z_31,
    output logic                 CE,
    input  logic                 flush,
    input  logic signed [W+GUARD:0] y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  y_out,
    output logic [1:0]           quad_out,
    output logic                 ovf_out
);
    localparam int XW = W + GUARD + 2;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    typedef struct packed {
        logic [W-1:0] y;
        logic [1:0]   quad;
        logic         ovf;
    } entry_t;

    state_e                 state_q, state_d;
    entry_t                 head_q, head_d, spare_q, spare_d, new_e;
    logic [STAGES-1:0][2:0] tag_q;
    logic                   push, pop;

    logic signed [XW-1:0]   y_ext, y_rnd;
    logic [GUARD+2:0]       top;
    logic                   ovf;
    logic [W-1:0]           y_sat;

    assign y_ext = {y_in[W+GUARD], y_in};
`ifdef CORDIC_Y_ROUND_EN
    localparam logic signed [XW-1:0] HALF = XW'(1) << (GUARD - 1);
    logic signed [XW-1:0] y_sum;
    assign y_sum = y_ext + HALF;
    assign y_rnd = y_sum >>> GUARD;
`else
    assign y_rnd = y_ext >>> GUARD;
`endif

    // Fits in W bits iff every bit from W-1 upward matches the sign.
    assign top   = y_rnd[XW-1:W-1];
    assign ovf   = ~(&top | ~|top);
    assign y_sat = ovf ? {y_rnd[XW-1], {(W-1){~y_rnd[XW-1]}}} : y_rnd[W-1:0];
    assign new_e = '{y: y_sat, quad: tag_q[STAGES-1][1:0], ovf: ovf};

    assign CE        = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = CE & tag_q[STAGES-1][2];
    assign pop       = out_valid & out_ready;
    assign y_out     = head_q.y;
    assign quad_out  = head_q.quad;
    assign ovf_out   = head_q.ovf;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            tag_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) tag_q[i][2] <= 1'b0;
        end else if (CE) begin
            tag_q[0] <= {in_valid, Z_31, Z_30};
            for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        spare_d = spare_q;
        case (state_q)
            EMPTY: if (push) begin
                head_d  = new_e;
                state_d = ONE;
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    spare_d = new_e;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) begin
                head_d  = spare_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= EMPTY;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            spare_q <= spare_d;
        end
    end
endmodule

// File: tb/tb_cordic_y_last_stage_drain.sv
// Directed bench for cordic_y_last_stage_drain at W=16, GUARD=2, STAGES=4.
// Expected Y values follow CORDIC_Y_ROUND_EN when defined, truncation otherwise.
module tb_cordic_y_last_stage_drain;
    localparam int W = 16, GUARD = 2, STAGES = 4;
`ifdef CORDIC_Y_ROUND_EN
    localparam logic [15:0] EXP_LAT  = 16'h0402;
    localparam logic [15:0] EXP_NEG6 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_LAT  = 16'h0401;
    localparam logic [15:0] EXP_NEG6 = 16'hFFFE;
`endif

    logic C, RN, in_valid, Z_30, Z_31, CE, flush, out_valid, out_ready, ovf_out;
    logic signed [W+GUARD:0] y_in;
    logic signed [W-1:0] y_out;
    logic [1:0] quad_out;
    int n_cmp, n_err;

    cordic_y_last_stage_drain #(.W(W), .GUARD(GUARD), .STAGES(STAGES)) dut (
        .C(C), .RN(RN), .in_valid(in_valid), .Z_30(Z_30), .Z_31(Z_31), .CE(CE),
        .flush(flush), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .quad_out(quad_out), .ovf_out(ovf_out)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic send_one(input logic [1:0] q, input logic signed [W+GUARD:0] y);
        in_valid = 1'b1; Z_31 = q[1]; Z_30 = q[0]; y_in = y;
        tick;
        in_valid = 1'b0;
        repeat (STAGES) tick;
    endtask

    task automatic test_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (y_out !== 16'h0000) begin n_err++; $display("FAIL reset_y: got %h want 0000", y_out); end
        n_cmp++; if (quad_out !== 2'b00) begin n_err++; $display("FAIL reset_quad: got %b want 00", quad_out); end
        n_cmp++; if (ovf_out !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_out); end
        n_cmp++; if (CE !== 1'b1) begin n_err++; $display("FAIL reset_ce: got %b want 1", CE); end
    endtask

    task automatic test_latency;
        out_ready = 1'b1;
        in_valid = 1'b1; Z_31 = 1'b1; Z_30 = 1'b0; y_in = 19'sd4102;
        tick;
        in_valid = 1'b0;
        repeat (STAGES - 1) tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", out_valid); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b want 1", out_valid); end
        n_cmp++; if (y_out !== EXP_LAT) begin n_err++; $display("FAIL lat_y: got %h want %h", y_out, EXP_LAT); end
        n_cmp++; if (quad_out !== 2'b10) begin n_err++; $display("FAIL lat_quad: got %b want 10", quad_out); end
        n_cmp++; if (ovf_out !== 1'b0) begin n_err++; $display("FAIL lat_ovf: got %b want 0", ovf_out); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_saturation;
        int          yv [3] = '{262143, -262144, -6};
        logic [15:0] ey [3];
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        ey[0] = 16'h7FFF; ey[1] = 16'h8000; ey[2] = EXP_NEG6;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_one(2'b01, 19'(yv[i]));
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (y_out !== ey[i]) begin n_err++; $display("FAIL sat_y[%0d]: got %h want %h", i, y_out, ey[i]); end
            n_cmp++; if (ovf_out !== eo[i]) begin n_err++; $display("FAIL sat_ovf[%0d]: got %b want %b", i, ovf_out, eo[i]); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] q;
        out_ready = 1'b1; y_in = 19'sd100;
        for (int i = 0; i <= 10; i++) begin
            q = 2'(i);
            in_valid = (i < 6); Z_31 = q[1]; Z_30 = q[0];
            tick;
            if (i >= 4 && i <= 9) begin
                q = 2'(i - 4);
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
                n_cmp++; if (quad_out !== q) begin n_err++; $display("FAIL b2b_quad[%0d]: got %b want %b", i, quad_out, q); end
                n_cmp++; if (y_out !== 16'h0019) begin n_err++; $display("FAIL b2b_y[%0d]: got %h want 0019", i, y_out); end
            end
            n_cmp++; if (CE !== 1'b1) begin n_err++; $display("FAIL b2b_ce[%0d]: got %b want 1", i, CE); end
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [1:0] q;
        out_ready = 1'b0; y_in = 19'sd100;
        for (int i = 0; i < 6; i++) begin
            q = 2'(i + 1);
            in_valid = (i < 3); Z_31 = q[1]; Z_30 = q[0];
            tick;
        end
        n_cmp++; if (CE !== 1'b0) begin n_err++; $display("FAIL bp_ce_low: got %b want 0", CE); end
        n_cmp++; if (quad_out !== 2'b01) begin n_err++; $display("FAIL bp_head: got %b want 01", quad_out); end
        in_valid = 1'b1; Z_31 = 1'b0; Z_30 = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        n_cmp++; if (out_valid !== 1'b1 || quad_out !== 2'b01 || y_out !== 16'h0019)
            begin n_err++; $display("FAIL bp_stable: got v=%b q=%b y=%h want v=1 q=01 y=0019", out_valid, quad_out, y_out); end
        n_cmp++; if (CE !== 1'b0) begin n_err++; $display("FAIL bp_ce_hold: got %b want 0", CE); end
        out_ready = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b1 || quad_out !== 2'b10) begin n_err++; $display("FAIL bp_out2: got v=%b q=%b want v=1 q=10", out_valid, quad_out); end
        n_cmp++; if (CE !== 1'b1) begin n_err++; $display("FAIL bp_ce_back: got %b want 1", CE); end
        tick;
        n_cmp++; if (out_valid !== 1'b1 || quad_out !== 2'b11) begin n_err++; $display("FAIL bp_out3: got v=%b q=%b want v=1 q=11", out_valid, quad_out); end
        for (int i = 0; i < 7; i++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra[%0d]: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_midop;
        logic seen;
        out_ready = 1'b0; y_in = 19'sd100;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3); Z_31 = 1'b0; Z_30 = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        #2 RN = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        n_cmp++; if (CE !== 1'b1) begin n_err++; $display("FAIL rst_mid_ce: got %b want 1", CE); end
        n_cmp++; if (y_out !== 16'h0000) begin n_err++; $display("FAIL rst_mid_y: got %h want 0000", y_out); end
        #1 RN = 1'b1;
        tick;
        out_ready = 1'b1; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            seen = seen | out_valid;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_ghost: got %b want 0", seen); end
        send_one(2'b11, 19'sd4102);
        n_cmp++; if (out_valid !== 1'b1 || quad_out !== 2'b11 || y_out !== EXP_LAT)
            begin n_err++; $display("FAIL rst_mid_new: got v=%b q=%b y=%h want v=1 q=11 y=%h", out_valid, quad_out, y_out, EXP_LAT); end
        tick;
    endtask

    task automatic test_flush;
        logic seen;
        out_ready = 1'b0; y_in = 19'sd100;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4); Z_31 = 1'b1; Z_30 = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        n_cmp++; if (CE !== 1'b0) begin n_err++; $display("FAIL flush_pre_ce: got %b want 0", CE); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_cmp++; if (CE !== 1'b1) begin n_err++; $display("FAIL flush_ce: got %b want 1", CE); end
        out_ready = 1'b1; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            seen = seen | out_valid;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_ghost: got %b want 0", seen); end
        send_one(2'b10, 19'sd100);
        n_cmp++; if (out_valid !== 1'b1 || quad_out !== 2'b10 || y_out !== 16'h0019)
            begin n_err++; $display("FAIL flush_new: got v=%b q=%b y=%h want v=1 q=10 y=0019", out_valid, quad_out, y_out); end
        tick;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        RN = 1'b0; in_valid = 1'b0; Z_30 = 1'b0; Z_31 = 1'b0; flush = 1'b0;
        out_ready = 1'b0; y_in = '0;
        #3;
        test_reset;
        #9 RN = 1'b1;
        tick;
        test_latency;
        test_saturation;
        test_back_to_back;
        test_backpressure;
        test_reset_midop;
        test_flush;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
